// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run-control unit: state and halt-cause
// encodings plus the helper that resolves coincident halt events.
package cpu_run_pkg;

   localparam int CAUSE_W = 2;

   // Encodings are visible on the debug state port, so they are fixed.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RESETTING = 3'd1,
      ST_RUN       = 3'd2,
      ST_STEP_WAIT = 3'd3,
      ST_HALT      = 3'd4
   } run_state_e;

   typedef enum logic [CAUSE_W-1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_USER    = 2'd1,
      CAUSE_BP      = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } halt_cause_e;

   // User stop wins over a breakpoint, which wins over the cycle budget.
   function automatic halt_cause_e pick_cause(input logic user_stop,
                                              input logic bp_stop,
                                              input logic budget_stop);
      if (user_stop)
         return CAUSE_USER;
      else if (bp_stop)
         return CAUSE_BP;
      else if (budget_stop)
         return CAUSE_TIMEOUT;
      else
         return CAUSE_NONE;
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_bp_match.sv
// Breakpoint comparator array: flags when the CPU PC equals any enabled
// breakpoint address. Purely combinational.
module bp_match #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_BP     = 2
) (
   input  logic [ADDR_WIDTH-1:0]        pc_i,
   input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr_i,
   input  logic [NUM_BP-1:0]            bp_en_i,
   output logic                         bp_hit_o
);

   logic [NUM_BP-1:0] entry_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BP; gi++) begin : g_entry
         // One equality comparator per breakpoint slot, gated by its enable.
         assign entry_hit[gi] = bp_en_i[gi] &&
                                (pc_i == bp_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]);
      end
   endgenerate

   assign bp_hit_o = |entry_hit;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run-control: sequences the CPU reset pulse, gates the CPU clock
// enable for free-run or single-step execution, halts on user stop,
// breakpoint or cycle budget, and reports retired cycles and halt cause.
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32,
   parameter int NUM_BP     = 2,
   parameter int RST_CYCLES = 4
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         start,
   input  logic                         resume,
   input  logic                         stop,
   input  logic                         step_mode,
   input  logic                         step,
   input  logic [CNT_WIDTH-1:0]         max_cycles,
   input  logic [ADDR_WIDTH-1:0]        pc_in,
   input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
   input  logic [NUM_BP-1:0]            bp_en,
   output logic                         cpu_reset,
   output logic                         cpu_clk_en,
   output logic [CNT_WIDTH-1:0]         cycle_count,
   output logic                         halted,
   output logic [CAUSE_W-1:0]           halt_cause,
   output logic [2:0]                   state
);

   localparam int RC_W = $clog2(RST_CYCLES + 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

   run_state_e           state_q, state_d;
   logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   halt_cause_e          cause_q, cause_d;
   logic                 mask_q, mask_d;

   logic bp_raw;
   logic bp_hit;
   logic budget_hit;
   logic halt_evt;
   logic executing;
   logic enter_reset;

   bp_match #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_BP     (NUM_BP)
   ) u_bp_match (
      .pc_i      (pc_in),
      .bp_addr_i (bp_addr),
      .bp_en_i   (bp_en),
      .bp_hit_o  (bp_raw)
   );

   // The breakpoint is ignored for one cycle after resume so the
   // instruction sitting at the breakpoint PC gets to execute.
   assign bp_hit     = bp_raw && !mask_q;
   assign budget_hit = (max_cycles != '0) && (count_q >= max_cycles);
   assign halt_evt   = stop || bp_hit || budget_hit;
   assign executing  = (state_q == ST_RUN) || (state_q == ST_STEP_WAIT);
   assign enter_reset = (state_d == ST_RESETTING) && (state_q != ST_RESETTING);

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic; start is only honoured from IDLE or HALT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start)
               state_d = ST_RESETTING;
         end
         ST_RESETTING: begin
            if (rst_cnt_q == RC_LAST)
               state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
         end
         ST_RUN, ST_STEP_WAIT: begin
            if (halt_evt)
               state_d = ST_HALT;
         end
         ST_HALT: begin
            if (start)
               state_d = ST_RESETTING;
            else if (resume)
               state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs; the clock enable drops in the same cycle as a halt event.
   always_comb begin
      cpu_reset  = 1'b0;
      cpu_clk_en = 1'b0;
      halted     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cpu_reset = 1'b1;
         end
         ST_RESETTING: begin
            cpu_reset  = 1'b1;
            cpu_clk_en = 1'b1;
         end
         ST_RUN: begin
            cpu_clk_en = !halt_evt;
         end
         ST_STEP_WAIT: begin
            cpu_clk_en = step && !halt_evt;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            cpu_reset = 1'b1;
         end
      endcase
   end

   // Next values for the reset-pulse counter, cycle counter, cause and mask.
   always_comb begin
      rst_cnt_d = (state_q == ST_RESETTING) ? rst_cnt_q + RC_W'(1) : '0;

      count_d = count_q;
      if (enter_reset)
         count_d = '0;
      else if (executing && cpu_clk_en && (count_q != '1))
         count_d = count_q + CNT_WIDTH'(1);

      cause_d = cause_q;
      if (enter_reset)
         cause_d = CAUSE_NONE;
      else if (executing && halt_evt)
         cause_d = pick_cause(stop, bp_hit, budget_hit);
      else if ((state_q == ST_HALT) && resume)
         cause_d = CAUSE_NONE;

      mask_d = (state_q == ST_HALT) && resume && !start;
   end

   // Datapath registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rst_cnt_q <= '0;
         count_q   <= '0;
         cause_q   <= CAUSE_NONE;
         mask_q    <= 1'b0;
      end else begin
         rst_cnt_q <= rst_cnt_d;
         count_q   <= count_d;
         cause_q   <= cause_d;
         mask_q    <= mask_d;
      end
   end

   assign cycle_count = count_q;
   assign halt_cause  = cause_q;
   assign state       = state_q;

endmodule
